// File: rtl/riscv_mem_responder_if.sv
// Request/response bundle between the Riscv141 core (master) and the
// memory responder (slave): fetch port, data port and the shared stall.
interface riscv_mem_responder_if;
   logic [31:0] icache_addr;
   logic        icache_re;
   logic [31:0] icache_dout;
   logic [31:0] dcache_addr;
   logic        dcache_re;
   logic [3:0]  dcache_we;
   logic [31:0] dcache_din;
   logic [31:0] dcache_dout;
   logic        stall;

   modport master (
      output icache_addr, icache_re, dcache_addr, dcache_re, dcache_we, dcache_din,
      input  icache_dout, dcache_dout, stall
   );

   modport slave (
      input  icache_addr, icache_re, dcache_addr, dcache_re, dcache_we, dcache_din,
      output icache_dout, dcache_dout, stall
   );
endinterface

// File: rtl/riscv_mem_responder.sv
// Word-organised memory responder for the Riscv141 fetch and data ports, with
// configurable wait latency and serialization of same-word write/fetch hazards.
module riscv_mem_responder #(
   parameter int unsigned ADDR_WORDS_LOG2 = 14,
   parameter int unsigned WAIT_CYCLES     = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   riscv_mem_responder_if.slave bus
);
   localparam int unsigned AW       = ADDR_WORDS_LOG2;
   localparam logic [3:0]  WAIT_CNT = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {ST_READY, ST_WAIT, ST_HAZ} state_e;

   logic [31:0] mem_q [0:(1<<AW)-1];

   state_e        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          stall_q, stall_d;
   logic          haz_q, haz_d;
   logic [AW-1:0] iidx_q, iidx_d, didx_q, didx_d;
   logic          ire_q, ire_d, dre_q, dre_d;
   logic [3:0]    dwe_q, dwe_d;
   logic [31:0]   din_q, din_d;
   logic [31:0]   idout_q, idout_d, ddout_q, ddout_d;

   logic [AW-1:0] iidx_in, didx_in, fetch_idx, data_idx;
   logic          d_active_in, haz_in, req_in;
   logic          fetch_fire, data_fire, fetch_en, data_en;
   logic [3:0]    data_we, mem_we;
   logic [31:0]   data_din;
   logic          unused_addr_bits;

   assign iidx_in     = bus.icache_addr[AW+1:2];
   assign didx_in     = bus.dcache_addr[AW+1:2];
   assign d_active_in = bus.dcache_re | (|bus.dcache_we);
   assign haz_in      = bus.icache_re & (|bus.dcache_we) & (iidx_in == didx_in);
   assign req_in      = bus.icache_re | d_active_in;

   assign unused_addr_bits = ^{bus.icache_addr[31:AW+2], bus.icache_addr[1:0],
                               bus.dcache_addr[31:AW+2], bus.dcache_addr[1:0]};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      haz_d      = haz_q;
      iidx_d     = iidx_q;
      didx_d     = didx_q;
      ire_d      = ire_q;
      dre_d      = dre_q;
      dwe_d      = dwe_q;
      din_d      = din_q;
      fetch_fire = 1'b0;
      data_fire  = 1'b0;
      fetch_idx  = iidx_q;
      data_idx   = didx_q;
      data_we    = dwe_q;
      data_din   = din_q;
      fetch_en   = ire_q;
      data_en    = dre_q | (|dwe_q);

      case (state_q)
         ST_READY: begin
            // Zero-latency accesses act straight from the bus at the accepting edge
            fetch_idx = iidx_in;
            data_idx  = didx_in;
            data_we   = bus.dcache_we;
            data_din  = bus.dcache_din;
            fetch_en  = bus.icache_re;
            data_en   = d_active_in;
            if (req_in) begin
               iidx_d = iidx_in;
               didx_d = didx_in;
               ire_d  = bus.icache_re;
               dre_d  = bus.dcache_re;
               dwe_d  = bus.dcache_we;
               din_d  = bus.dcache_din;
               haz_d  = haz_in;
               if (WAIT_CNT == 4'd0) begin
                  data_fire  = 1'b1;
                  fetch_fire = ~haz_in;
                  state_d    = haz_in ? ST_HAZ : ST_READY;
                  cnt_d      = haz_in ? 4'd1 : 4'd0;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_CNT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd1) begin
               data_fire = 1'b1;
               if (haz_q) begin
                  state_d = ST_HAZ;
                  cnt_d   = WAIT_CNT + 4'd1;
               end else begin
                  fetch_fire = 1'b1;
                  state_d    = ST_READY;
                  cnt_d      = 4'd0;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_HAZ: begin
            if (cnt_q == 4'd1) begin
               fetch_fire = 1'b1;
               state_d    = ST_READY;
               cnt_d      = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = ST_READY;
            cnt_d   = 4'd0;
         end
      endcase

      stall_d = (state_d != ST_READY);
      // Reads sample the array before this edge's write: read-before-write on the data port
      idout_d = (fetch_fire && fetch_en) ? mem_q[fetch_idx] : idout_q;
      ddout_d = (data_fire && data_en)   ? mem_q[data_idx]  : ddout_q;
      mem_we  = (data_fire && !reset)    ? data_we          : '0;
   end

   always_ff @(posedge clk) begin
      for (int unsigned l = 0; l < 4; l++) begin
         if (mem_we[l]) begin
            mem_q[data_idx][8*l +: 8] <= data_din[8*l +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_READY;
         cnt_q   <= '0;
         stall_q <= 1'b0;
         haz_q   <= 1'b0;
         iidx_q  <= '0;
         didx_q  <= '0;
         ire_q   <= 1'b0;
         dre_q   <= 1'b0;
         dwe_q   <= '0;
         din_q   <= '0;
         idout_q <= '0;
         ddout_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stall_q <= stall_d;
         haz_q   <= haz_d;
         iidx_q  <= iidx_d;
         didx_q  <= didx_d;
         ire_q   <= ire_d;
         dre_q   <= dre_d;
         dwe_q   <= dwe_d;
         din_q   <= din_d;
         idout_q <= idout_d;
         ddout_q <= ddout_d;
      end
   end

   assign bus.icache_dout = idout_q;
   assign bus.dcache_dout = ddout_q;
   assign bus.stall       = stall_q;
endmodule
